// File: rtl/noc_out_arbiter.sv
// Packet-granular round-robin arbiter for one NoC router output port.
// It grants one input FIFO per packet, drains exactly PACKET_LEN flits from it,
// and forwards them one cycle later to the downstream FIFO write side.
module noc_out_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACKET_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] in_data,
  output logic [N_REQ-1:0]            rd_en,
  input  logic                        down_ordy,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_wr_en,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic [15:0]                 pkt_count
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN + 1) : 1;

  localparam logic [CW-1:0]    LastCnt = CW'(PACKET_LEN - 1);
  // Pointer resets to the last requester so requester 0 wins the first arbitration.
  localparam logic [PW-1:0]    PtrRst  = PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] OneHot0 = {{(N_REQ - 1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e                  r_state, w_state_d;
  logic [N_REQ-1:0]        r_grant, w_grant_d;
  logic [PW-1:0]           r_ptr, w_ptr_d;
  logic [CW-1:0]           r_cnt, w_cnt_d;
  logic [DATA_WIDTH-1:0]   r_out_data, w_out_data_d;
  logic                    r_out_wr_en, w_out_wr_en_d;
  logic [15:0]             r_pkt_count, w_pkt_count_d;

  logic                    w_found;
  logic [PW-1:0]           w_winner;
  logic [PW-1:0]           w_idx;
  logic [N_REQ-1:0]        w_ptr_onehot;
  logic [N_REQ-1:0]        w_win_onehot;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_last_flit;

  // Round-robin search: first requester after the last winner, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      w_idx = PW'((int'(r_ptr) + k) % int'(N_REQ));
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Decode helpers: owner one-hot, winner one-hot, head flit of the owner.
  always_comb begin
    w_ptr_onehot = OneHot0 << r_ptr;
    w_win_onehot = OneHot0 << w_winner;
    w_sel_data   = in_data[int'(r_ptr) * int'(DATA_WIDTH) +: DATA_WIDTH];
    w_last_flit  = (r_cnt == LastCnt);
  end

  // Next-state and datapath next values; defaults hold state, write strobe idles low.
  always_comb begin
    w_state_d     = r_state;
    w_grant_d     = r_grant;
    w_ptr_d       = r_ptr;
    w_cnt_d       = r_cnt;
    w_out_data_d  = r_out_data;
    w_out_wr_en_d = 1'b0;
    w_pkt_count_d = r_pkt_count;
    unique case (r_state)
      StIdle: begin
        // A packet starts only when the downstream FIFO can absorb all of it.
        if (down_ordy && w_found) begin
          w_state_d = StXfer;
          w_grant_d = w_win_onehot;
          w_ptr_d   = w_winner;
          w_cnt_d   = '0;
        end
      end
      StXfer: begin
        // req and down_ordy are deliberately ignored; the packet always completes.
        w_out_data_d  = w_sel_data;
        w_out_wr_en_d = 1'b1;
        w_cnt_d       = r_cnt + CW'(1);
        if (w_last_flit) begin
          w_state_d     = StIdle;
          w_grant_d     = '0;
          w_pkt_count_d = r_pkt_count + 16'd1;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_grant_d = '0;
      end
    endcase
  end

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Arbitration and output datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant     <= '0;
      r_ptr       <= PtrRst;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_wr_en <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_grant     <= w_grant_d;
      r_ptr       <= w_ptr_d;
      r_cnt       <= w_cnt_d;
      r_out_data  <= w_out_data_d;
      r_out_wr_en <= w_out_wr_en_d;
      r_pkt_count <= w_pkt_count_d;
    end
  end

  // Pop strobe is a pure function of state so the FIFO sees it in the first XFER cycle.
  always_comb begin
    busy      = (r_state == StXfer);
    rd_en     = busy ? w_ptr_onehot : '0;
    grant     = r_grant;
    out_data  = r_out_data;
    out_wr_en = r_out_wr_en;
    pkt_count = r_pkt_count;
  end

  // Structural invariants of the grant/pop relationship.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset) $onehot0(r_grant));
  a_rd_matches_grant : assert property (@(posedge clk) disable iff (reset)
    busy |-> (rd_en == r_grant));
  a_idle_no_rd : assert property (@(posedge clk) disable iff (reset) !busy |-> (rd_en == '0));

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Self-checking bench for noc_out_arbiter: a per-cycle vector table plus
// hand-written round-robin and counter-wrap sequences.
module tb_noc_out_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int PL = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      rd_en;
  logic              down_ordy;
  logic [DW-1:0]     out_data;
  logic              out_wr_en;
  logic [N-1:0]      grant;
  logic              busy;
  logic [15:0]       pkt_count;

  always #5 clk = ~clk;

  noc_out_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .PACKET_LEN (PL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in_data   (in_data),
    .rd_en     (rd_en),
    .down_ordy (down_ordy),
    .out_data  (out_data),
    .out_wr_en (out_wr_en),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  // Upstream FIFO model: head of FIFO i is 0xA1 + 16*i + (flits popped so far).
  logic [7:0] pops [N];

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) pops[i] <= 8'd0;
      else if (rd_en[i]) pops[i] <= pops[i] + 8'd1;
    end
  end

  always_comb begin
    in_data = '0;
    for (int i = 0; i < N; i++) begin
      in_data[i*DW +: DW] = 8'hA1 + 8'(16 * i) + pops[i];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         ordy;
    logic [N-1:0] grant;
    logic [N-1:0] rd;
    logic         wr;
    logic [DW-1:0] data;
    logic         busy;
    logic [15:0]  pkt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [N-1:0] rq, input logic ordy,
                     input logic [N-1:0] g, input logic [N-1:0] rd, input logic wr,
                     input logic [DW-1:0] d, input logic bsy, input logic [15:0] pc);
    vec_t v;
    v.rst = rst; v.req = rq; v.ordy = ordy; v.grant = g; v.rd = rd;
    v.wr = wr; v.data = d; v.busy = bsy; v.pkt = pc;
    vecs.push_back(v);
  endtask

  // Drive one packet from the given requesters and let it run to completion.
  task automatic run_packet(input logic [N-1:0] rq);
    @(negedge clk);
    req = rq;
    down_ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = '0;
    repeat (PL) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0]  exp_g;
    logic [DW-1:0] exp_d;
    int            ph, p, s;

    reset = 1'b1;
    req = '0;
    down_ordy = 1'b1;

    // Row: inputs before an edge, expected outputs just after it.
    //   rst req     ordy grant   rd_en   wr data   busy pkt
    add(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'd0);  // reset
    add(1, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'd0);
    add(0, 4'b0001, 1, 4'b0001, 4'b0001, 0, 8'h00, 1, 16'd0);  // grant after release
    add(0, 4'b0001, 1, 4'b0001, 4'b0001, 1, 8'hA1, 1, 16'd0);
    add(0, 4'b0001, 1, 4'b0001, 4'b0001, 1, 8'hA2, 1, 16'd0);
    add(0, 4'b0001, 1, 4'b0001, 4'b0001, 1, 8'hA3, 1, 16'd0);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'hA4, 0, 16'd1);  // last flit
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'hA4, 0, 16'd1);  // data holds
    add(0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 8'hA4, 0, 16'd1);  // back-pressure
    add(0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 8'hA4, 0, 16'd1);
    add(0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 8'hA4, 0, 16'd1);
    add(0, 4'b0100, 0, 4'b0000, 4'b0000, 0, 8'hA4, 0, 16'd1);
    add(0, 4'b0100, 1, 4'b0100, 4'b0100, 0, 8'hA4, 1, 16'd1);  // ordy raised
    add(0, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'hC1, 1, 16'd1);  // ordy dropped mid-packet
    add(0, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'hC2, 1, 16'd1);
    add(0, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'hC3, 1, 16'd1);
    add(0, 4'b0011, 0, 4'b0000, 4'b0000, 1, 8'hC4, 0, 16'd2);
    add(0, 4'b0011, 1, 4'b0001, 4'b0001, 0, 8'hC4, 1, 16'd2);  // ptr=2 wraps to 0
    add(0, 4'b0011, 1, 4'b0001, 4'b0001, 1, 8'hA5, 1, 16'd2);
    add(0, 4'b0011, 1, 4'b0001, 4'b0001, 1, 8'hA6, 1, 16'd2);
    add(0, 4'b0011, 1, 4'b0001, 4'b0001, 1, 8'hA7, 1, 16'd2);
    add(0, 4'b0011, 1, 4'b0000, 4'b0000, 1, 8'hA8, 0, 16'd3);
    add(0, 4'b0011, 1, 4'b0010, 4'b0010, 0, 8'hA8, 1, 16'd3);  // then requester 1
    add(0, 4'b0011, 1, 4'b0010, 4'b0010, 1, 8'hB1, 1, 16'd3);  // 2nd flit popping
    add(1, 4'b0011, 1, 4'b0000, 4'b0000, 0, 8'h00, 0, 16'd0);  // reset mid-packet
    add(0, 4'b0011, 1, 4'b0001, 4'b0001, 0, 8'h00, 1, 16'd0);  // restart from 0
    add(0, 4'b0011, 1, 4'b0001, 4'b0001, 1, 8'hA1, 1, 16'd0);
    add(0, 4'b0011, 1, 4'b0001, 4'b0001, 1, 8'hA2, 1, 16'd0);
    add(0, 4'b0011, 1, 4'b0001, 4'b0001, 1, 8'hA3, 1, 16'd0);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 1, 8'hA4, 0, 16'd1);
    add(0, 4'b0000, 1, 4'b0000, 4'b0000, 0, 8'hA4, 0, 16'd1);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      req = vecs[i].req;
      down_ordy = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d {grant,rd_en,wr,data,busy,pkt}", i),
            64'({grant, rd_en, out_wr_en, out_data, busy, pkt_count}),
            64'({vecs[i].grant, vecs[i].rd, vecs[i].wr, vecs[i].data, vecs[i].busy,
                 vecs[i].pkt}));
    end

    // Round-robin with all four requesting: grants 0,1,2,3,0 with one idle cycle between.
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    down_ordy = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      ph = k % 5;
      p  = k / 5;
      s  = p % N;
      exp_g = (ph == 4) ? 4'b0000 : (4'b0001 << s);
      check($sformatf("rr%0d grant", k), 64'(grant), 64'(exp_g));
      check($sformatf("rr%0d busy", k), 64'(busy), 64'(ph != 4));
      if (ph == 0) begin
        check($sformatf("rr%0d wr_en", k), 64'(out_wr_en), 64'd0);
      end else begin
        exp_d = 8'hA1 + 8'(16 * s) + 8'(4 * (p / N)) + 8'(ph - 1);
        check($sformatf("rr%0d wr/data", k), 64'({out_wr_en, out_data}),
              64'({1'b1, exp_d}));
      end
    end
    check("rr pkt_count", 64'(pkt_count), 64'd5);
    @(negedge clk);
    req = '0;

    // Counter wrap: preload near the top, then complete two packets.
    @(negedge clk);
    force dut.r_pkt_count = 16'hFFFE;
    #1;
    release dut.r_pkt_count;
    @(posedge clk);
    #1;
    check("wrap preload", 64'(pkt_count), 64'hFFFE);
    run_packet(4'b0100);
    check("wrap to FFFF", 64'(pkt_count), 64'hFFFF);
    run_packet(4'b0100);
    check("wrap to 0000", 64'(pkt_count), 64'h0000);
    @(posedge clk);
    #1;
    check("idle after wrap", 64'({grant, rd_en, busy, out_wr_en}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
Packet-granular round-robin arbiter for one router output port of the hypercube NoC. Up to N_REQ input-port FIFOs compete for a single output link. The arbiter grants one FIFO per packet and holds that grant for exactly PACKET_LEN flits. It drains the granted FIFO with rd_en and forwards the flits, registered, to the downstream FIFO's write side. A new packet is started only while the downstream FIFO reports room for a whole packet (its ordy).

Parameters:
N_REQ, 4, number of requesting input FIFOs (2..8)
DATA_WIDTH, `DATA_WIDTH, flit width in bits
PACKET_LEN, `PACKET_LEN, flits per packet (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req  input  N_REQ  req[i]=1: FIFO i holds at least one complete packet (PACKET_LEN flits)
in_data  input  N_REQ*DATA_WIDTH  head flits; slice i = in_data[i*DATA_WIDTH +: DATA_WIDTH]
rd_en  output  N_REQ  pop strobe to FIFO i, combinational from state
down_ordy  input  1  downstream FIFO has space for one full packet
out_data  output  DATA_WIDTH  registered flit to downstream FIFO
out_wr_en  output  1  registered write strobe to downstream FIFO
grant  output  N_REQ  one-hot current owner, 0 when idle
busy  output  1  1 while in XFER
pkt_count  output  16  packets completed, wraps at 0xFFFF->0

Behaviour:
- One clock; reset is synchronous and active-high, sampled on rising clk.
- Reset has priority over all other activity, including mid-packet.
- Reset values: state=IDLE; grant=0; rd_en=0; out_wr_en=0; out_data=0; busy=0; pkt_count=0; flit counter=0; rr pointer=N_REQ-1, so requester 0 has first priority.
- State machine has two states, IDLE and XFER.
- IDLE:
  - rd_en=0 and busy=0.
  - If down_ordy=1 and req!=0, choose the winner as the first i with req[i]=1, scanning (ptr+1) mod N_REQ upward with wrap.
  - At that edge: grant<=onehot(winner); ptr<=winner; cnt<=0; state<=XFER.
  - If down_ordy=0, no grant is made, whatever req is.
- XFER:
  - rd_en[g]=1 every cycle for the granted index g; all other rd_en bits are 0.
  - Each edge: out_data<=in_data slice g; out_wr_en<=1; cnt<=cnt+1.
  - At cnt==PACKET_LEN-1 the edge also does: state<=IDLE; grant<=0; pkt_count<=pkt_count+1.
- In any cycle with no XFER flit, out_wr_en is registered to 0. out_data holds its last value.
- Latency:
  - First rd_en is asserted in the cycle after the grant edge.
  - Each flit appears on out_data/out_wr_en one cycle after its rd_en cycle.
- Throughput: one packet per PACKET_LEN+1 cycles. The one IDLE cycle between packets is mandatory, because arbitration happens only in IDLE.
- req and down_ordy are ignored during XFER. The packet always completes, since both were checked at packet start.
- A req[i] that drops mid-packet is ignored; such a drop is a protocol violation by the source.
- Fairness: the previous winner gets lowest priority at the next arbitration. With all N_REQ requesting, each is served once every N_REQ packets.
- A single requester is re-granted back-to-back (ptr wraps to itself).
- If reset is asserted mid-XFER, the partially forwarded packet is abandoned. Upstream and downstream FIFOs are reset by the same signal.
- Widths: cnt is $clog2(PACKET_LEN+1) bits; ptr is $clog2(N_REQ) bits. All additions wrap naturally in their own width.

Test Plan:
- Reset then single requester: PACKET_LEN=4, req=4'b0001, down_ordy=1, in_data[0] steps through 0xA1..0xA4.
  - Required: grant=0001 one cycle after reset release.
  - rd_en[0]=1 for 4 cycles.
  - out_wr_en=1 for 4 cycles carrying 0xA1,0xA2,0xA3,0xA4, one cycle behind rd_en.
  - pkt_count=1 afterwards.
- Round-robin, all requesting: req=4'b1111 held.
  - Required: grant order is 0,1,2,3,0, with exactly one IDLE cycle between grants.
  - pkt_count=5 after 25 cycles of activity.
- Skip and wrap: ptr=2 (last winner was 2), req=4'b0011.
  - Required: next grant goes to requester 0, then to 1.
- Back-pressure:
  - down_ordy=0 with req=4'b0100: stays IDLE, grant=0, rd_en=0 indefinitely.
  - Raise down_ordy: grant=0100 on the next edge.
  - Drop down_ordy mid-XFER: the packet still completes all 4 flits.
- Reset mid-packet: assert reset during the 2nd flit of a transfer.
  - Required: next cycle grant=0, rd_en=0, out_wr_en=0, busy=0, pkt_count=0.
  - Re-arbitration starts from requester 0.
- pkt_count wrap: preload by running 65536 packets, or force.
  - Required: count reads 0xFFFF then 0x0000.
